kernel_sysid_arbiter: RTL and testbench
=======================================

// Module: kernel_sysid_arbiter
// PURPOSE
//  Shares the single read-only system-ID slave (addr 0 = ID, addr 1 = timestamp) among NUM_REQ
//  Avalon-MM read masters using round-robin arbitration.
//  After reset, it sequences a self-check of both words against expected values before serving requests.
//  Sits between the kernel interconnect masters and the sysid control_slave; the slave is purely combinational.
// PARAMETERS
//  NUM_REQ      2               number of requesters (1..8)
//  EXPECTED_ID  32'd0           value the ID word (addr 0) must return
//  EXPECTED_TS  32'd1533475449  value the timestamp word (addr 1) must return
// PORTS
//  clock              in   1        single clock
//  reset              in   1        asynchronous, active-high reset
//  req_read           in   NUM_REQ  per-requester read strobe, held until accepted
//  req_address        in   NUM_REQ  per-requester word address (bit i = requester i)
//  req_waitrequest    out  NUM_REQ  1 = request i not accepted this cycle
//  req_readdatavalid  out  NUM_REQ  one-cycle pulse to the requester owning req_readdata
//  req_readdata       out  32       shared response data
//  sys_address        out  1        registered address to the sysid slave
//  sys_readdata       in   32       sysid slave data (combinational from sys_address)
//  check_done         out  1        boot self-check finished
//  check_fail         out  1        boot self-check mismatch (valid when check_done=1)
// BEHAVIOUR
//  Reset values: sys_address=0, req_readdata=0, req_readdatavalid=0, check_done=0, check_fail=0,
//   rr pointer=NUM_REQ-1 (requester 0 has top priority first), state=BOOT_ID.
//  FSM (all outputs registered except req_waitrequest):
//   BOOT_ID  : sys_address<=1 -> BOOT_TS; id_ok<=(sys_readdata==EXPECTED_ID).
//   BOOT_TS  : check_fail<=~id_ok | (sys_readdata!=EXPECTED_TS); check_done<=1 -> IDLE.
//   IDLE     : if |req_read: grant winner g (round-robin, search from ptr+1 upward, wrap at NUM_REQ);
//              sys_address<=req_address[g]; ptr<=g; owner<=g -> CAPTURE. Otherwise stay.
//   CAPTURE  : req_readdata<=sys_readdata -> RESP.
//   RESP     : req_readdatavalid[owner]=1 for exactly this cycle -> IDLE.
//  req_waitrequest[i] = ~(state==IDLE && grant[i]); forced to all-ones in BOOT_* and when reset is high.
//  Latency: accepted in cycle T (waitrequest low); readdatavalid at T+2. Throughput: one read per 3 cycles.
//  Only one requester is granted at a time; the grant vector is one-hot or zero.
//  A requester that drops req_read while waiting loses nothing; the pointer updates only on grant.
//  Simultaneous requests: the closest requester after ptr wins. With all requesting, grants rotate 0,1,..,N-1,0.
//  req_readdata holds its last value outside RESP; consumers sample only on readdatavalid.
//  Reset mid-operation: an in-flight read is dropped (no readdatavalid) and the boot check reruns.
//  check_done/check_fail stay latched until the next reset; the check result never blocks service.
// CONFIGURATION
//  SYSID_ARB_BOOTCHECK_EN defined: BOOT_ID/BOOT_TS sequence as above.
//  SYSID_ARB_BOOTCHECK_EN undefined: BOOT states are removed and the FSM leaves reset in IDLE;
//   check_done=1 and check_fail=0 constant (reset value also 1/0). The EXPECTED_* parameters are unused.
// STRUCTURE
//  Package kernel_sysid_pkg: state enum (BOOT_ID, BOOT_TS, IDLE, CAPTURE, RESP),
//   SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, and the SYSID_DATA_W=32 constant.
//  Sub-module kernel_rr_arbiter: combinational round-robin picker
//   (inputs: req vector, ptr; outputs: one-hot grant, encoded index).
// TESTING
//  1. Reset release, slave returns 0 / 1533475449 -> check_done=1 after 2 cycles, check_fail=0;
//     waitrequest all-ones until then.
//  2. Slave ID returns 32'h1 -> check_done=1, check_fail=1; later requests are still served.
//  3. Only req0 reads addr 1 -> waitrequest0 low in T; readdatavalid0 at T+2 with data 1533475449;
//     req1 signals stay idle.
//  4. req0 and req1 hold read continuously -> grants alternate 0,1,0,1; each readdatavalid goes to the
//     correct owner; no back-to-back grant to the same requester.
//  5. Assert reset during CAPTURE -> no readdatavalid; the boot check reruns; check_done returns to 0 then 1.
//  6. Build without SYSID_ARB_BOOTCHECK_EN -> request at the first post-reset cycle is accepted immediately;
//     check_done=1 and check_fail=0 throughout.

Source files
------------

// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the sysid read arbiter.
// The boot self-check is compiled in only when SYSID_ARB_BOOTCHECK_EN is defined.
package kernel_sysid_pkg;

   localparam int SYSID_DATA_W = 32;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      BOOT_ID,
      BOOT_TS,
      IDLE,
      CAPTURE,
      RESP
   } state_t;

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kernel_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap,
// returns a one-hot (or zero) grant and the winner's encoded index.
module kernel_rr_arbiter
   import kernel_sysid_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand     = (int'(ptr) + off) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found            = 1'b1;
            grant[cand_idx]  = 1'b1;
            grant_idx        = cand_idx;
         end
      end
   end

endmodule

// File: rtl/kernel_sysid_arbiter.sv
// Round-robin sharing of the combinational sysid slave among NUM_REQ read masters.
// SYSID_ARB_BOOTCHECK_EN adds a post-reset ID/timestamp self-check before service starts.
//
// state   | meaning
// BOOT_ID | sample ID word, point slave at timestamp
// BOOT_TS | sample timestamp, latch check_done/check_fail
// IDLE    | grant one requester, launch its address
// CAPTURE | register slave data
// RESP    | readdatavalid pulse to owner
module kernel_sysid_arbiter
   import kernel_sysid_pkg::*;
#(
   parameter int                      NUM_REQ     = 2,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID = 32'd0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS = 32'd1533475449
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_read,
   input  logic [NUM_REQ-1:0]      req_address,
   output logic [NUM_REQ-1:0]      req_waitrequest,
   output logic [NUM_REQ-1:0]      req_readdatavalid,
   output logic [SYSID_DATA_W-1:0] req_readdata,
   output logic                    sys_address,
   input  logic [SYSID_DATA_W-1:0] sys_readdata,
   output logic                    check_done,
   output logic                    check_fail
);

   localparam int               IDX_W     = idx_width(NUM_REQ);
   localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        ptr, ptr_nxt;
   logic [IDX_W-1:0]        owner, owner_nxt;
   logic [IDX_W-1:0]        grant_idx;
   logic [NUM_REQ-1:0]      grant;
   logic [NUM_REQ-1:0]      rdv_nxt;
   logic                    sys_address_nxt;
   logic [SYSID_DATA_W-1:0] readdata_nxt;

`ifdef SYSID_ARB_BOOTCHECK_EN
   localparam state_t RESET_STATE = BOOT_ID;
   logic id_ok, id_ok_nxt;
   logic done_nxt, fail_nxt;
`else
   localparam state_t RESET_STATE = IDLE;
   logic unused_cfg;
   assign unused_cfg = ^{EXPECTED_ID, EXPECTED_TS};
   assign check_done = 1'b1;
   assign check_fail = 1'b0;
`endif

   kernel_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req       (req_read),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_nxt       = state;
      ptr_nxt         = ptr;
      owner_nxt       = owner;
      sys_address_nxt = sys_address;
      readdata_nxt    = req_readdata;
      rdv_nxt         = '0;
`ifdef SYSID_ARB_BOOTCHECK_EN
      id_ok_nxt       = id_ok;
      done_nxt        = check_done;
      fail_nxt        = check_fail;
`endif
      case (state)
`ifdef SYSID_ARB_BOOTCHECK_EN
         BOOT_ID: begin
            id_ok_nxt       = (sys_readdata == EXPECTED_ID);
            sys_address_nxt = SYSID_ADDR_TS;
            state_nxt       = BOOT_TS;
         end
         BOOT_TS: begin
            fail_nxt  = ~id_ok | (sys_readdata != EXPECTED_TS);
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
`endif
         IDLE: begin
            if (|req_read) begin
               sys_address_nxt = req_address[grant_idx];
               ptr_nxt         = grant_idx;
               owner_nxt       = grant_idx;
               state_nxt       = CAPTURE;
            end
         end
         CAPTURE: begin
            readdata_nxt   = sys_readdata;
            rdv_nxt[owner] = 1'b1;
            state_nxt      = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = RESET_STATE;
      endcase
   end

   // Reset forces stall combinationally so nothing is accepted while it is held.
   always_comb begin
      req_waitrequest = '1;
      if (!reset && state == IDLE) req_waitrequest = ~grant;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= RESET_STATE;
         ptr               <= PTR_RESET;
         owner             <= '0;
         sys_address       <= SYSID_ADDR_ID;
         req_readdata      <= '0;
         req_readdatavalid <= '0;
`ifdef SYSID_ARB_BOOTCHECK_EN
         id_ok             <= 1'b0;
         check_done        <= 1'b0;
         check_fail        <= 1'b0;
`endif
      end else begin
         state             <= state_nxt;
         ptr               <= ptr_nxt;
         owner             <= owner_nxt;
         sys_address       <= sys_address_nxt;
         req_readdata      <= readdata_nxt;
         req_readdatavalid <= rdv_nxt;
`ifdef SYSID_ARB_BOOTCHECK_EN
         id_ok             <= id_ok_nxt;
         check_done        <= done_nxt;
         check_fail        <= fail_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_kernel_sysid_arbiter.sv
// Scoreboard bench for kernel_sysid_arbiter; adapts to SYSID_ARB_BOOTCHECK_EN.
module tb_kernel_sysid_arbiter;

   localparam int          NUM_REQ = 2;
   localparam logic [31:0] EXP_ID  = 32'd0;
   localparam logic [31:0] EXP_TS  = 32'd1533475449;
`ifdef SYSID_ARB_BOOTCHECK_EN
   localparam bit BOOT_EN = 1'b1;
`else
   localparam bit BOOT_EN = 1'b0;
`endif

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [NUM_REQ-1:0] req_read, req_address, req_waitrequest, req_readdatavalid;
   logic [31:0]        req_readdata, sys_readdata;
   logic               sys_address, check_done, check_fail;
   logic [31:0]        id_val, ts_val;

   always #5 clock = ~clock;

   // Ideal combinational sysid slave.
   assign sys_readdata = sys_address ? ts_val : id_val;

   kernel_sysid_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .EXPECTED_ID (EXP_ID),
      .EXPECTED_TS (EXP_TS)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .req_read          (req_read),
      .req_address       (req_address),
      .req_waitrequest   (req_waitrequest),
      .req_readdatavalid (req_readdatavalid),
      .req_readdata      (req_readdata),
      .sys_address       (sys_address),
      .sys_readdata      (sys_readdata),
      .check_done        (check_done),
      .check_fail        (check_fail)
   );

   typedef struct {
      int          idx;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t               sb[$];
   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 step_idx = 0;
   int                 ptr_m;
   int                 n_acc = 0;
   bit                 release_pending = 1'b0;
   logic [NUM_REQ-1:0] pend = '0, pend_addr = '0, hold = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_idx);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c;
         c = (p + k) % NUM_REQ;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic monitor();
      logic exp_done, exp_fail;
      exp_t e;
      exp_done = !BOOT_EN || (step_idx >= 2);
      exp_fail = BOOT_EN && (step_idx >= 2) && ((id_val !== EXP_ID) || (ts_val !== EXP_TS));
      chk("check_done", 32'(check_done), 32'(exp_done));
      chk("check_fail", 32'(check_fail), 32'(exp_fail));
      if (req_readdatavalid != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_rdv", 32'(req_readdatavalid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rdv_owner", 32'(req_readdatavalid), 32'd1 << e.idx);
            chk("rdv_data", req_readdata, e.data);
            chk("rdv_latency", step_idx, e.due);
         end
      end else if (sb.size() != 0 && sb[0].due <= step_idx) begin
         e = sb.pop_front();
         chk("rdv_missing", 32'(req_readdatavalid), 32'd1 << e.idx);
      end
   endtask

   // One clock cycle: observe registered outputs, drive requests, record acceptance.
   task automatic step();
      logic [NUM_REQ-1:0] acc;
      int                 exp_idx;
      @(negedge clock);
      if (release_pending) begin
         reset           = 1'b0;
         release_pending = 1'b0;
         step_idx        = 0;
      end else begin
         step_idx++;
         monitor();
      end
      req_read    = pend;
      req_address = pend_addr;
      #1;
      acc = req_read & ~req_waitrequest;
      if (acc != '0) begin
         exp_idx = rr_pick(pend, ptr_m);
         chk("grant_onehot", $countones(acc), 32'd1);
         chk("grant_idx", 32'(acc), 32'd1 << exp_idx);
         sb.push_back('{exp_idx, pend_addr[exp_idx] ? ts_val : id_val, step_idx + 2});
         ptr_m          = exp_idx;
         pend[exp_idx]  = hold[exp_idx];
         n_acc++;
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      sb.delete();
      pend     = '0;
      hold     = '0;
      ptr_m    = NUM_REQ - 1;
      req_read = '1;
      #1;
      chk("rst_sys_address", 32'(sys_address), 32'd0);
      chk("rst_readdata", req_readdata, 32'd0);
      chk("rst_rdv", 32'(req_readdatavalid), 32'd0);
      chk("rst_check_done", 32'(check_done), 32'(!BOOT_EN));
      chk("rst_check_fail", 32'(check_fail), 32'd0);
      chk("rst_waitrequest", 32'(req_waitrequest), 32'({NUM_REQ{1'b1}}));
      repeat (2) @(negedge clock);
      chk("rst_rdv_held", 32'(req_readdatavalid), 32'd0);
      release_pending = 1'b1;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         step();
         guard++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      int n0;
      id_val      = EXP_ID;
      ts_val      = EXP_TS;
      req_read    = '0;
      req_address = '0;
      #2;
      do_reset();

      // Request present from the first post-reset cycle.
      pend      = 2'b01;
      pend_addr = 2'b00;
      n0        = n_acc;
      step();
`ifdef SYSID_ARB_BOOTCHECK_EN
      chk("boot_wait0", 32'(req_waitrequest), 32'({NUM_REQ{1'b1}}));
      step();
      chk("boot_wait1", 32'(req_waitrequest), 32'({NUM_REQ{1'b1}}));
      chk("boot_no_accept", n_acc - n0, 32'd0);
`else
      chk("early_accept", n_acc - n0, 32'd1);
`endif
      drain();

      // Lone requester 0 reading the timestamp.
      pend      = 2'b01;
      pend_addr = 2'b01;
      n0        = n_acc;
      step();
      chk("t3_accept_now", n_acc - n0, 32'd1);
      chk("t3_wr1_idle", 32'(req_waitrequest[1]), 32'd1);
      drain();

      // Lone requester 1 reading the ID.
      pend      = 2'b10;
      pend_addr = 2'b00;
      step();
      drain();

      // Both hold read continuously: alternation, one grant per 3 cycles.
      hold      = 2'b11;
      pend      = 2'b11;
      pend_addr = 2'b10;
      n0        = n_acc;
      repeat (12) step();
      chk("t4_grant_count", n_acc - n0, 32'd4);
      hold = '0;
      pend = '0;
      drain();

      // Reset while CAPTURE: read dropped, boot check reruns.
      pend      = 2'b01;
      pend_addr = 2'b00;
      step();
      step();
      do_reset();
      repeat (5) step();

`ifdef SYSID_ARB_BOOTCHECK_EN
      // Bad ID word: check fails but service continues.
      id_val = 32'h1;
      do_reset();
      repeat (3) step();
      pend      = 2'b10;
      pend_addr = 2'b00;
      step();
      drain();
      step();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
